// File: rtl/sd_sector_reader.sv
// Port-mapped front end for the SD SPI byte controller: raw byte pass-through
// plus an autonomous 512-byte sector-read engine with a CPU-drained buffer.
module sd_sector_reader #(
  parameter logic [15:0] BASE        = 16'h2C,
  parameter int          TOKEN_LIMIT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_o,
  input  logic        we,
  input  logic        read,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  output logic        irq
);

  localparam int TW = (TOKEN_LIMIT > 2) ? $clog2(TOKEN_LIMIT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAITB, DONE, ERR} state_t;
  typedef enum logic [1:0] {PH_TOKEN, PH_DATA, PH_CRC} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [8:0]    wcnt, wcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          done, done_n;
  logic          tok_to, tok_to_n;
  logic          irq_n;
  logic          sig_n;
  logic [1:0]    cmd_n;
  logic [7:0]    out_n;
  logic          buf_we;
  logic          ptr_zero;
  logic [8:0]    ptr;
  logic [7:0]    buf_q;
  logic [7:0]    mem [512];

  logic [15:0]   offset;
  logic          wr_data, wr_cmd, wr_ctrl, wr_buf, rd_buf;
  logic          raw_ok;
  logic          engine_busy;

  // Offset arithmetic wraps, so the decode works for any BASE alignment.
  assign offset      = address - BASE;
  assign hit         = (offset < 16'd4);
  assign wr_data     = we   && hit && (offset[1:0] == 2'd0);
  assign wr_cmd      = we   && hit && (offset[1:0] == 2'd1);
  assign wr_ctrl     = we   && hit && (offset[1:0] == 2'd2);
  assign wr_buf      = we   && hit && (offset[1:0] == 2'd3);
  assign rd_buf      = read && hit && (offset[1:0] == 2'd3);
  assign engine_busy = (state != IDLE);
  // A pulse already in flight has not raised sd_busy yet, so it also blocks.
  assign raw_ok      = !sd_busy && !sd_signal;

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (offset[1:0])
        2'd0:    rdata = sd_din;
        2'd1:    rdata = {6'b0, sd_timeout, sd_busy};
        2'd2:    rdata = {4'b0, done, sd_timeout, tok_to, engine_busy};
        default: rdata = buf_q;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    wcnt_n   = wcnt;
    tcnt_n   = tcnt;
    done_n   = done;
    tok_to_n = tok_to;
    irq_n    = 1'b0;
    sig_n    = 1'b0;
    cmd_n    = sd_cmd;
    out_n    = sd_out;
    buf_we   = 1'b0;
    ptr_zero = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && data_o[0]) begin
          tcnt_n   = '0;
          wcnt_n   = '0;
          done_n   = 1'b0;
          tok_to_n = 1'b0;
          phase_n  = PH_TOKEN;
          state_n  = ISSUE;
        end else if (wr_data && raw_ok) begin
          sig_n = 1'b1;
          cmd_n = 2'd0;
          out_n = data_o;
        end else if (wr_cmd && raw_ok) begin
          sig_n = 1'b1;
          cmd_n = data_o[1:0];
          out_n = 8'hFF;
        end
      end
      ISSUE: begin
        sig_n   = 1'b1;
        cmd_n   = 2'd0;
        out_n   = 8'hFF;
        state_n = SETTLE;
      end
      SETTLE: state_n = WAITB;
      WAITB: begin
        if (!sd_busy) begin
          if (sd_timeout) begin
            state_n = ERR;
          end else begin
            state_n = ISSUE;
            case (phase)
              PH_TOKEN: begin
                if (sd_din == 8'hFE) begin
                  wcnt_n  = '0;
                  phase_n = PH_DATA;
                end else if (tcnt == TW'(TOKEN_LIMIT - 1)) begin
                  tok_to_n = 1'b1;
                  state_n  = ERR;
                end else begin
                  tcnt_n = tcnt + TW'(1);
                end
              end
              PH_DATA: begin
                buf_we = 1'b1;
                if (wcnt == 9'd511) begin
                  phase_n = PH_CRC;
                  wcnt_n  = '0;
                end else begin
                  wcnt_n = wcnt + 9'd1;
                end
              end
              PH_CRC: begin
                if (wcnt[0]) state_n = DONE;
                else         wcnt_n  = wcnt + 9'd1;
              end
              default: state_n = ERR;
            endcase
          end
        end
      end
      DONE: begin
        done_n   = 1'b1;
        irq_n    = 1'b1;
        ptr_zero = 1'b1;
        state_n  = IDLE;
      end
      ERR: begin
        done_n  = 1'b1;
        irq_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PH_TOKEN;
      wcnt      <= '0;
      tcnt      <= '0;
      done      <= 1'b0;
      tok_to    <= 1'b0;
      irq       <= 1'b0;
      sd_signal <= 1'b0;
      sd_cmd    <= 2'd0;
      sd_out    <= 8'hFF;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      wcnt      <= wcnt_n;
      tcnt      <= tcnt_n;
      done      <= done_n;
      tok_to    <= tok_to_n;
      irq       <= irq_n;
      sd_signal <= sig_n;
      sd_cmd    <= cmd_n;
      sd_out    <= out_n;
    end
  end

  // A clear (CPU write or engine DONE) wins over a same-cycle read increment.
  always_ff @(posedge clock) begin
    if (reset)                   ptr <= '0;
    else if (ptr_zero || wr_buf) ptr <= '0;
    else if (rd_buf)             ptr <= ptr + 9'd1;
  end

  always_ff @(posedge clock) begin
    if (buf_we) mem[wcnt] <= sd_din;
    buf_q <= mem[ptr];
  end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Directed bench for sd_sector_reader with a behavioural SD byte-controller model.
module tb_sd_sector_reader;

  localparam logic [15:0] BASE  = 16'h2C;
  localparam int          LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_o;
  logic        we;
  logic        read;
  logic [7:0]  rdata;
  logic        hit;
  logic        sd_signal;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_out;
  logic [7:0]  sd_din;
  logic        sd_busy;
  logic        sd_timeout;
  logic        irq;

  sd_sector_reader #(.BASE(BASE), .TOKEN_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .address(address), .data_o(data_o),
    .we(we), .read(read), .rdata(rdata), .hit(hit),
    .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout), .irq(irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Controller model state: mode 0 raw (3C), 1 sector, 2 all FF, 3 sector with timeout.
  int         mode = 0;
  int         pat_off = 0;
  int         base = 0;
  int         xfer = 0;
  int         irq_count = 0;
  int         viol = 0;
  logic       sig_prev = 1'b0;
  logic [1:0] last_cmd = 2'd0;
  logic [7:0] last_out = 8'h00;
  logic [7:0] m_resp = 8'h00;
  logic       m_to_pend = 1'b0;
  int         m_bcnt = 0;

  function automatic logic [7:0] respond(input int n);
    if (mode == 0) return 8'h3C;
    if (mode == 2) return 8'hFF;
    if (n < 2)     return 8'hFF;
    if (n == 2)    return 8'hFE;
    if (n < 515)   return 8'((n - 3 + pat_off) & 255);
    if (n == 515)  return 8'h12;
    if (n == 516)  return 8'h34;
    return 8'hFF;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      sd_busy    <= 1'b0;
      sd_timeout <= 1'b0;
      sd_din     <= 8'h00;
      m_bcnt     <= 0;
    end else if (sd_signal) begin
      sd_busy    <= 1'b1;
      sd_timeout <= 1'b0;
      m_bcnt     <= 3;
      m_resp     <= respond(xfer - base);
      m_to_pend  <= (mode == 3) && ((xfer - base) == 7);
      last_cmd   <= sd_cmd;
      last_out   <= sd_out;
      xfer       <= xfer + 1;
    end else if (sd_busy) begin
      if (m_bcnt == 1) begin
        sd_busy    <= 1'b0;
        sd_din     <= m_resp;
        sd_timeout <= m_to_pend;
      end else begin
        m_bcnt <= m_bcnt - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (sd_signal && (sd_busy || sig_prev)) viol <= viol + 1;
      if (irq) irq_count <= irq_count + 1;
    end
    sig_prev <= sd_signal && !reset;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic writeReg(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a; data_o = d; we = 1'b1;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    #1 d = rdata;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic waitIrq(input string tag);
    int start = irq_count;
    int cyc = 0;
    while (irq_count == start && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    repeat (4) @(negedge clock);
    checkOutput(tag, irq_count - start, 1);
  endtask

  task automatic waitPulses(input int target, input string tag);
    int cyc = 0;
    while ((xfer - base) < target && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput(tag, 32'((xfer - base) >= target), 1);
  endtask

  task automatic startSector(input int m, input int off);
    mode = m; pat_off = off; base = xfer;
    writeReg(BASE + 16'd2, 8'h01);
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1; address = 16'h0; data_o = 8'h0; we = 1'b0; read = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state and address decode
    #1;
    checkOutput("rst_signal", sd_signal, 0);
    checkOutput("rst_cmd", sd_cmd, 0);
    checkOutput("rst_out", sd_out, 8'hFF);
    checkOutput("rst_irq", irq, 0);
    readReg(BASE + 16'd2, v);
    checkOutput("rst_ctrl", v, 8'h00);
    address = BASE + 16'd4; #1 checkOutput("hit_above", hit, 0);
    address = BASE - 16'd1; #1 checkOutput("hit_below", hit, 0);
    address = BASE + 16'd3; #1 checkOutput("hit_top", hit, 1);

    // Raw pass-through
    mode = 0; base = xfer;
    writeReg(BASE, 8'hA5);
    repeat (10) @(negedge clock);
    checkOutput("raw_pulses", xfer - base, 1);
    checkOutput("raw_cmd", last_cmd, 0);
    checkOutput("raw_out", last_out, 8'hA5);
    readReg(BASE, v);
    checkOutput("raw_din", v, 8'h3C);
    readReg(BASE + 16'd1, v);
    checkOutput("raw_status", v, 8'h00);
    writeReg(BASE + 16'd1, 8'h02);
    repeat (10) @(negedge clock);
    checkOutput("cmdw_pulses", xfer - base, 2);
    checkOutput("cmdw_cmd", last_cmd, 2);
    checkOutput("cmdw_out", last_out, 8'hFF);

    // Sector read with lockout attempts mid-transfer
    startSector(1, 0);
    waitPulses(20, "sec_progress");
    readReg(BASE + 16'd2, v);
    checkOutput("sec_busy_bit", v & 8'h01, 1);
    writeReg(BASE, 8'h55);
    writeReg(BASE + 16'd2, 8'h01);
    waitIrq("sec_irq");
    checkOutput("sec_pulses", xfer - base, 517);
    readReg(BASE + 16'd2, v);
    checkOutput("sec_ctrl", v, 8'h08);
    for (int i = 0; i < 512; i++) begin
      readReg(BASE + 16'd3, v);
      checkOutput("buf_data", v, i & 255);
    end
    readReg(BASE + 16'd3, v);
    checkOutput("buf_wrap", v, 8'h00);
    readReg(BASE + 16'd3, v);
    checkOutput("buf_after_wrap", v, 8'h01);
    writeReg(BASE + 16'd3, 8'h00);
    readReg(BASE + 16'd3, v);
    checkOutput("buf_clear", v, 8'h00);

    // Token timeout
    startSector(2, 0);
    waitIrq("tok_irq");
    checkOutput("tok_pulses", xfer - base, LIMIT);
    readReg(BASE + 16'd2, v);
    checkOutput("tok_ctrl", v, 8'h0A);

    // Controller timeout on the fifth data byte
    startSector(3, 0);
    waitIrq("cto_irq");
    checkOutput("cto_pulses", xfer - base, 8);
    readReg(BASE + 16'd2, v);
    checkOutput("cto_ctrl", v, 8'h0C);

    // Reset mid-transfer, then a clean restart
    startSector(1, 8'h80);
    waitPulses(103, "rst_progress");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1 checkOutput("midrst_signal", sd_signal, 0);
    readReg(BASE + 16'd2, v);
    checkOutput("midrst_ctrl", v, 8'h00);
    readReg(BASE + 16'd3, v);
    checkOutput("midrst_ptr", v, 8'h80);
    startSector(1, 0);
    waitIrq("restart_irq");
    checkOutput("restart_pulses", xfer - base, 517);
    readReg(BASE + 16'd2, v);
    checkOutput("restart_ctrl", v, 8'h08);
    for (int i = 0; i < 4; i++) begin
      readReg(BASE + 16'd3, v);
      checkOutput("restart_buf", v, i);
    end

    checkOutput("signal_protocol", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
